// File: rtl/mod_counter_updown.sv
// Programmable modulus up/down counter with runtime limit, load and free-running/one-shot run modes.
// Optional wrap event counter enabled by defining MOD_COUNTER_WRAP_COUNT_EN.
module mod_counter_updown #(
    parameter int N  = 4,
    parameter int WC = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         dir,
    input  logic [N-1:0] limit,
    input  logic         mode_oneshot,
    input  logic         start,
    input  logic         load,
    input  logic [N-1:0] load_val,
    output logic [N-1:0] Q,
    output logic         tc,
    output logic         wrap,
    output logic         busy,
    output logic         done
`ifdef MOD_COUNTER_WRAP_COUNT_EN
    ,
    output logic [WC-1:0] wrap_cnt
`endif
);

    if (N < 2 || WC < 1) begin : g_param_check
        $error("mod_counter_updown: N must be >= 2 and WC >= 1");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state, state_n;
    logic [N-1:0] q_n;
    logic         wrap_n;
    logic         terminal;
    logic [N-1:0] start_val;
    logic [N-1:0] load_clamped;

    assign terminal     = dir ? (Q >= limit) : (Q == '0);
    assign start_val    = dir ? '0 : limit;
    assign load_clamped = (load_val > limit) ? limit : load_val;

    assign tc   = (state == RUN) && terminal;
    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_comb begin
        state_n = state;
        q_n     = Q;
        wrap_n  = 1'b0;
        if (load) begin
            q_n = load_clamped;
            if (state == DONE) begin
                state_n = IDLE;
            end
        end else if (start) begin
            q_n     = start_val;
            state_n = RUN;
        end else if (state == RUN && en) begin
            if (terminal) begin
                wrap_n = 1'b1;
                if (mode_oneshot) begin
                    state_n = DONE;
                end else begin
                    q_n = start_val;
                end
            end else if (dir) begin
                q_n = Q + 1'b1;
            end else begin
                // A limit lowered beneath Q pulls a down-count straight back into range.
                q_n = (Q > limit) ? limit : (Q - 1'b1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            Q     <= '0;
            wrap  <= 1'b0;
        end else begin
            state <= state_n;
            Q     <= q_n;
            wrap  <= wrap_n;
        end
    end

`ifdef MOD_COUNTER_WRAP_COUNT_EN
    // Counts registered wrap pulses; a start that is not overridden by load clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            wrap_cnt <= '0;
        end else if (start && !load) begin
            wrap_cnt <= '0;
        end else if (wrap && (wrap_cnt != {WC{1'b1}})) begin
            wrap_cnt <= wrap_cnt + 1'b1;
        end
    end
`endif

endmodule
